trs80_kbd_matrix: RTL and testbench



---
 rtl/trs80_kbd_matrix_pkg.sv | 25 ++
 rtl/trs80_kbd_matrix_if.sv | 9 +
 rtl/trs80_kbd_lut.sv | 90 +++++++++
 rtl/trs80_kbd_matrix.sv | 124 ++++++++++++
 tb/tb_trs80_kbd_matrix.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/trs80_kbd_matrix_pkg.sv
// rtl/trs80_kbd_matrix_pkg.sv - shared types and scancode constants for the TRS-80 keyboard matrix
package trs80_kbd_pkg;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } kbd_event_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_F12    = 8'h07;
    localparam logic [2:0] ROW_SHIFT = 3'd7;

    function automatic kbd_pos_t mk_pos(input logic [2:0] r, input logic [2:0] c);
        return {1'b1, r, c};
    endfunction

endpackage

// File: rtl/trs80_kbd_matrix_if.sv
// rtl/trs80_kbd_matrix_if.sv - host key bundle, CPU row select and column return
interface trs80_kbd_matrix_if;
    logic [10:0] ps2_key_i;
    logic [7:0]  rows_i;
    logic [7:0]  cols_o;

    modport master (output ps2_key_i, output rows_i, input cols_o);
    modport slave  (input ps2_key_i, input rows_i, output cols_o);
endinterface

// File: rtl/trs80_kbd_lut.sv
// rtl/trs80_kbd_lut.sv - combinational set-2 scancode to matrix position ROM
// KBD_PCLAYOUT_EN adds PC symbol remaps that carry a forced shift value.
module trs80_kbd_lut
    import trs80_kbd_pkg::*;
(
    input  logic       extended,
    input  logic [7:0] code,
`ifdef KBD_PCLAYOUT_EN
    input  logic       shift,
    output logic       remap,
    output logic       force_val,
`endif
    output kbd_pos_t   pos
);

    always_comb begin
        pos = '0;
        case ({extended, code})
            9'h00E: pos = mk_pos(3'd0, 3'd0);
            9'h01C: pos = mk_pos(3'd0, 3'd1);
            9'h032: pos = mk_pos(3'd0, 3'd2);
            9'h021: pos = mk_pos(3'd0, 3'd3);
            9'h023: pos = mk_pos(3'd0, 3'd4);
            9'h024: pos = mk_pos(3'd0, 3'd5);
            9'h02B: pos = mk_pos(3'd0, 3'd6);
            9'h034: pos = mk_pos(3'd0, 3'd7);
            9'h033: pos = mk_pos(3'd1, 3'd0);
            9'h043: pos = mk_pos(3'd1, 3'd1);
            9'h03B: pos = mk_pos(3'd1, 3'd2);
            9'h042: pos = mk_pos(3'd1, 3'd3);
            9'h04B: pos = mk_pos(3'd1, 3'd4);
            9'h03A: pos = mk_pos(3'd1, 3'd5);
            9'h031: pos = mk_pos(3'd1, 3'd6);
            9'h044: pos = mk_pos(3'd1, 3'd7);
            9'h04D: pos = mk_pos(3'd2, 3'd0);
            9'h015: pos = mk_pos(3'd2, 3'd1);
            9'h02D: pos = mk_pos(3'd2, 3'd2);
            9'h01B: pos = mk_pos(3'd2, 3'd3);
            9'h02C: pos = mk_pos(3'd2, 3'd4);
            9'h03C: pos = mk_pos(3'd2, 3'd5);
            9'h02A: pos = mk_pos(3'd2, 3'd6);
            9'h01D: pos = mk_pos(3'd2, 3'd7);
            9'h022: pos = mk_pos(3'd3, 3'd0);
            9'h035: pos = mk_pos(3'd3, 3'd1);
            9'h01A: pos = mk_pos(3'd3, 3'd2);
            9'h045: pos = mk_pos(3'd4, 3'd0);
            9'h016: pos = mk_pos(3'd4, 3'd1);
            9'h01E: pos = mk_pos(3'd4, 3'd2);
            9'h026: pos = mk_pos(3'd4, 3'd3);
            9'h025: pos = mk_pos(3'd4, 3'd4);
            9'h02E: pos = mk_pos(3'd4, 3'd5);
            9'h036: pos = mk_pos(3'd4, 3'd6);
            9'h03D: pos = mk_pos(3'd4, 3'd7);
            9'h03E: pos = mk_pos(3'd5, 3'd0);
            9'h046: pos = mk_pos(3'd5, 3'd1);
            9'h052: pos = mk_pos(3'd5, 3'd2);
            9'h04C: pos = mk_pos(3'd5, 3'd3);
            9'h041: pos = mk_pos(3'd5, 3'd4);
            9'h04E: pos = mk_pos(3'd5, 3'd5);
            9'h049: pos = mk_pos(3'd5, 3'd6);
            9'h04A: pos = mk_pos(3'd5, 3'd7);
            9'h05A: pos = mk_pos(3'd6, 3'd0);
            9'h005: pos = mk_pos(3'd6, 3'd1);
            9'h076: pos = mk_pos(3'd6, 3'd2);
            9'h175: pos = mk_pos(3'd6, 3'd3);
            9'h172: pos = mk_pos(3'd6, 3'd4);
            9'h16B: pos = mk_pos(3'd6, 3'd5);
            9'h174: pos = mk_pos(3'd6, 3'd6);
            9'h029: pos = mk_pos(3'd6, 3'd7);
            {1'b0, SC_LSHIFT}: pos = mk_pos(ROW_SHIFT, 3'd0);
            {1'b0, SC_RSHIFT}: pos = mk_pos(ROW_SHIFT, 3'd1);
            default: pos = '0;
        endcase
`ifdef KBD_PCLAYOUT_EN
        // Shift+2 is '@' (unshifted on the TRS-80); quote is Shift+7.
        remap     = 1'b0;
        force_val = 1'b0;
        if (!extended && shift && code == 8'h1E) begin
            remap     = 1'b1;
            force_val = 1'b0;
            pos       = mk_pos(3'd0, 3'd0);
        end else if (!extended && code == 8'h52) begin
            remap     = 1'b1;
            force_val = 1'b1;
            pos       = mk_pos(3'd4, 3'd7);
        end
`endif
    end

endmodule

// File: rtl/trs80_kbd_matrix.sv
// rtl/trs80_kbd_matrix.sv - host key events to TRS-80 Model III 8x8 matrix plus F12 reset stretch
// KBD_PCLAYOUT_EN enables the PC-layout symbol remap with shift override.
module trs80_kbd_matrix
    import trs80_kbd_pkg::*;
#(
    parameter int CLKFREQ_KHZ = 20000,
    parameter int RST_MS      = 50
) (
    input  logic              clock_i,
    input  logic              reset_i,
    trs80_kbd_matrix_if.slave kbd,
    output logic              reset_req_o,
    output logic              shift_o
);

    localparam int             RST_CYC  = RST_MS * CLKFREQ_KHZ;
    localparam int             CW       = $clog2(RST_CYC + 1);
    localparam logic [CW-1:0]  RST_LOAD = CW'(RST_CYC - 1);

    logic             strobe_last;
    logic             armed;
    logic             ev_pend;
    kbd_event_t       ev_q;
    kbd_pos_t         pos;
    logic [7:0][7:0]  key_q;
    logic [7:0][7:0]  eff_key;
    logic [7:0]       cols_q;
    logic [7:0]       cols_next;
    logic [CW-1:0]    rst_cnt;

`ifdef KBD_PCLAYOUT_EN
    logic remap;
    logic force_val;
    logic ovr_force;
    logic ovr_shift;
`endif

    trs80_kbd_lut u_lut (
        .extended  (ev_q.extended),
        .code      (ev_q.code),
`ifdef KBD_PCLAYOUT_EN
        .shift     (shift_o),
        .remap     (remap),
        .force_val (force_val),
`endif
        .pos       (pos)
    );

    // The first clock out of reset only samples the toggle so a pre-set strobe is not an event.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            strobe_last <= 1'b0;
            armed       <= 1'b0;
            ev_pend     <= 1'b0;
            ev_q        <= '0;
        end else begin
            ev_pend <= 1'b0;
            if (!armed) begin
                strobe_last <= kbd.ps2_key_i[10];
                armed       <= 1'b1;
            end else if (kbd.ps2_key_i[10] != strobe_last) begin
                strobe_last <= kbd.ps2_key_i[10];
                ev_pend     <= 1'b1;
                ev_q        <= kbd.ps2_key_i[9:0];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            key_q <= '0;
`ifdef KBD_PCLAYOUT_EN
            ovr_force <= 1'b0;
            ovr_shift <= 1'b0;
`endif
        end else if (ev_pend && pos.valid) begin
            key_q[pos.row][pos.col] <= ev_q.pressed;
`ifdef KBD_PCLAYOUT_EN
            if (remap) begin
                ovr_force <= ev_q.pressed;
                ovr_shift <= force_val;
            end
`endif
        end
    end

    always_comb begin
        eff_key = key_q;
`ifdef KBD_PCLAYOUT_EN
        if (ovr_force) eff_key[ROW_SHIFT][1:0] = {2{ovr_shift}};
`endif
    end

    always_comb begin
        cols_next = '0;
        for (int r = 0; r < 8; r++) begin
            if (!kbd.rows_i[r]) cols_next = cols_next | eff_key[r];
        end
    end

    // reset_req_o is registered so it stays high for exactly RST_CYC clocks after the load.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cols_q      <= '0;
            rst_cnt     <= '0;
            reset_req_o <= 1'b0;
        end else begin
            cols_q <= cols_next;
            if (ev_pend && ev_q.pressed && !ev_q.extended && ev_q.code == SC_F12) begin
                rst_cnt     <= RST_LOAD;
                reset_req_o <= 1'b1;
            end else if (rst_cnt != '0) begin
                rst_cnt     <= rst_cnt - 1'b1;
                reset_req_o <= 1'b1;
            end else begin
                reset_req_o <= 1'b0;
            end
        end
    end

    assign kbd.cols_o = cols_q;
    assign shift_o    = key_q[ROW_SHIFT][0] | key_q[ROW_SHIFT][1];

endmodule

// File: tb/tb_trs80_kbd_matrix.sv
// tb/tb_trs80_kbd_matrix.sv - randomized scoreboard bench for trs80_kbd_matrix
module tb_trs80_kbd_matrix;

    localparam int RST_CYC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reset_req;
    logic shift;

    always #5 clk = ~clk;

    trs80_kbd_matrix_if kif ();

    trs80_kbd_matrix #(.CLKFREQ_KHZ(10), .RST_MS(1)) dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .kbd         (kif),
        .reset_req_o (reset_req),
        .shift_o     (shift)
    );

    typedef struct {
        int         due;
        logic [7:0] cols;
        logic       shft;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         win_s[$];
    int         win_e[$];
    bit         mk[8][8];
    int         keymap[int];
    logic [8:0] pool[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    bit         strobe     = 1'b1;

    logic [8:0] tbl [8][8] = '{
        '{9'h00E, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034},
        '{9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044},
        '{9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D},
        '{9'h022, 9'h035, 9'h01A, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF},
        '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D},
        '{9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A},
        '{9'h05A, 9'h005, 9'h076, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029},
        '{9'h012, 9'h059, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_cols(input logic [7:0] rows);
        logic [7:0] v = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!rows[r] && mk[r][c]) v[c] = 1'b1;
        return v;
    endfunction

    // Monitor: reset request every cycle, queued column expectations when due.
    always @(negedge clk) begin
        logic exp_req;
        exp_t e;
        exp_req = 1'b0;
        for (int i = 0; i < win_s.size(); i++)
            if (cyc >= win_s[i] && cyc <= win_e[i]) exp_req = 1'b1;
        check("reset_req", {31'b0, reset_req}, {31'b0, exp_req});
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({"cols_", e.name}, {24'b0, kif.cols_o}, {24'b0, e.cols});
            check({"shift_", e.name}, {31'b0, shift}, {31'b0, e.shft});
        end
    end

    task automatic drive_evt(input bit p, input bit ext, input logic [7:0] code);
        int k;
        @(posedge clk); #1;
        strobe = ~strobe;
        kif.ps2_key_i = {strobe, p, ext, code};
        k = {ext, code};
        if (keymap.exists(k)) mk[keymap[k] / 8][keymap[k] % 8] = p;
        if (!ext && code == 8'h07 && p) begin
            win_s.push_back(cyc + 2);
            win_e.push_back(cyc + 1 + RST_CYC);
        end
    endtask

    task automatic send(input bit p, input bit ext, input logic [7:0] code);
        drive_evt(p, ext, code);
        repeat (3) @(posedge clk);
    endtask

    task automatic push_rows(input logic [7:0] rows, input string name);
        @(posedge clk); #1;
        kif.rows_i = rows;
        sb.push_back('{cyc + 1, exp_cols(rows), mk[7][0] | mk[7][1], name});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (tbl[r][c] != 9'h1FF) begin
                    keymap[int'(tbl[r][c])] = r * 8 + c;
                    pool.push_back(tbl[r][c]);
                end
        pool.push_back(9'h075);
        pool.push_back(9'h11C);
        pool.push_back(9'h000);
        pool.push_back(9'h15A);
        pool.push_back(9'h007);
        pool.push_back(9'h007);

        kif.ps2_key_i = 11'h400;
        kif.rows_i    = 8'hFF;
        rst           = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_cols", {24'b0, kif.cols_o}, 32'h0);
        check("rst_shift", {31'b0, shift}, 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        push_rows(8'h00, "no_spurious");

        send(1, 0, 8'h1C);
        push_rows(8'hFE, "a_make");
        send(0, 0, 8'h1C);
        push_rows(8'hFE, "a_break");

        send(1, 1, 8'h75);
        push_rows(8'hBF, "up_make");
        send(0, 1, 8'h75);
        send(1, 0, 8'h75);
        for (int r = 0; r < 8; r++) push_rows(~(8'h01 << r), "plain75");
        push_rows(8'h00, "plain75_all");
        send(0, 0, 8'h75);

        send(1, 0, 8'h1C);
        send(1, 0, 8'h5A);
        send(1, 0, 8'h5A);
        push_rows(8'hBE, "a_enter");
        push_rows(8'hFF, "rows_ff");
        send(0, 0, 8'h1C);
        send(0, 0, 8'h5A);

        drive_evt(1, 0, 8'h07);
        repeat (4) @(posedge clk);
        drive_evt(1, 0, 8'h07);
        repeat (20) @(posedge clk);
        send(0, 0, 8'h07);
        push_rows(8'h00, "f12_not_matrix");
        drive_evt(1, 0, 8'h07);
        repeat (14) @(posedge clk);

        send(1, 0, 8'h12);
        push_rows(8'h7F, "lshift");
        drain();
        @(posedge clk); #3;
        rst = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mk[r][c] = 1'b0;
        win_s.delete();
        win_e.delete();
        #1;
        check("async_rst_cols", {24'b0, kif.cols_o}, 32'h0);
        check("async_rst_shift", {31'b0, shift}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        send(1, 0, 8'h59);
        push_rows(8'h7F, "rearm");
        send(0, 0, 8'h59);

        for (int i = 0; i < 150; i++) begin
            logic [8:0] k;
            k = pool[$urandom_range(0, pool.size() - 1)];
            send($urandom_range(0, 9) < 6, k[8], k[7:0]);
            push_rows(8'($urandom), "rand");
            push_rows(8'($urandom), "rand");
        end
        push_rows(8'h00, "final_all");
        drain();
        repeat (15) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
